// File: rtl/mv_sched_pkg.sv
`default_nettype none
// +-------------------------------------------------------------+
// | mv_sched_pkg : shared types for the mv_sched request sched.  |
// | Revision     : 1.0                                          |
// +-------------------------------------------------------------+
package mv_sched_pkg;

  localparam int MV_LATENCY = 4;
  localparam int MV_ID_W    = 3;

  typedef logic [3:0][31:0]  vec4_t;
  typedef logic [15:0][31:0] mat4_t;

  typedef struct packed {
    logic [MV_ID_W-1:0] id;
    vec4_t              data;
  } rsp_t;

endpackage
`default_nettype wire

// File: rtl/mv_sched_fifo.sv
`default_nettype none
// +-------------------------------------------------------------+
// | mv_sched_fifo : result FIFO, push and pop allowed when full |
// | Revision      : 1.0                                         |
// +-------------------------------------------------------------+
module mv_sched_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  T                             i_din,
  input  logic                         i_pop,
  output T                             o_dout,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty,
  output logic                         o_overflow
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = $clog2(DEPTH + 1);

  T                r_mem [DEPTH];
  logic [c_aw-1:0] r_wr;
  logic [c_aw-1:0] r_rd;
  logic [c_cw-1:0] r_cnt;
  logic            w_pop;
  logic            w_push;

  assign o_full     = (r_cnt == c_cw'(DEPTH));
  assign o_empty    = (r_cnt == '0);
  assign w_pop      = i_pop & ~o_empty;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign w_push     = i_push & (~o_full | w_pop);
  assign o_overflow = i_push & o_full & ~w_pop;
  assign o_dout     = r_mem[r_rd];
  assign o_count    = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= r_wr + c_aw'(1);
      end
      if (w_pop) r_rd <= r_rd + c_aw'(1);
      r_cnt <= r_cnt + c_cw'(w_push) - c_cw'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mv_sched.sv
`default_nettype none
// +-------------------------------------------------------------+
// | mv_sched : round-robin vector scheduler and result buffer   |
// | Revision : 1.0                                              |
// +-------------------------------------------------------------+
module mv_sched
  import mv_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int LATENCY = MV_LATENCY,
  parameter int DEPTH   = 8,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     mat_ld,
  input  logic [511:0]        mat_i,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*128-1:0] req_vec,
  output logic                dp_m_valid,
  output logic [511:0]        dp_m,
  output logic                dp_in_valid,
  output logic [127:0]        dp_v,
  input  logic                dp_out_valid,
  input  logic [127:0]        dp_o,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [127:0]        rsp_data,
  output logic                busy,
  output logic                err
);
  localparam int c_cw = $clog2(DEPTH + 1);
  localparam int c_gw = $clog2(LATENCY + 2);

  mat4_t              r_bank [NREQ];
  logic [NREQ-1:0]    r_mat_vld;
  logic [IDW-1:0]     r_rr;
  logic               r_iss_vld;
  logic [IDW-1:0]     r_iss_id;
  vec4_t              r_dp_v;
  mat4_t              r_dp_m;
  logic [LATENCY-1:0] r_tag_vld;
  logic [IDW-1:0]     r_tag_id [LATENCY];
  logic [c_gw-1:0]    r_guard;
  logic               r_err;

  logic [NREQ-1:0]    w_gnt;
  logic               w_any;
  logic [IDW-1:0]     w_gnt_id;
  int                 w_idx;
  int                 w_inflight;
  logic               w_credit_ok;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic               w_ovf;
  logic [c_cw-1:0]    w_cnt;
  rsp_t               w_din;
  rsp_t               w_dout;

  // Every accepted request owns a FIFO slot until it is popped.
  always_comb begin
    w_inflight = int'(r_iss_vld);
    for (int k = 0; k < LATENCY; k++) w_inflight += int'(r_tag_vld[k]);
    w_credit_ok = ~w_full && ((int'(w_cnt) + w_inflight) < DEPTH);
  end

  always_comb begin
    w_gnt    = '0;
    w_any    = 1'b0;
    w_gnt_id = '0;
    w_idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = int'(r_rr) + i;
      if (w_idx >= NREQ) w_idx -= NREQ;
      if (!w_any && req_valid[w_idx] && r_mat_vld[w_idx] && w_credit_ok) begin
        w_any        = 1'b1;
        w_gnt[w_idx] = 1'b1;
        w_gnt_id     = IDW'(w_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREQ; r++)
      if (mat_ld[r]) r_bank[r] <= mat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mat_vld <= '0;
      r_rr      <= '0;
      r_iss_vld <= 1'b0;
      r_iss_id  <= '0;
      r_dp_v    <= '0;
      r_dp_m    <= '0;
      r_tag_vld <= '0;
      for (int k = 0; k < LATENCY; k++) r_tag_id[k] <= '0;
      r_guard   <= c_gw'(LATENCY + 1);
      r_err     <= 1'b0;
    end else begin
      r_mat_vld <= r_mat_vld | mat_ld;
      r_iss_vld <= w_any;
      if (w_any) begin
        r_iss_id <= w_gnt_id;
        r_dp_v   <= req_vec[int'(w_gnt_id)*128 +: 128];
        r_dp_m   <= r_bank[w_gnt_id];
        r_rr     <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);
      end
      r_tag_vld[0] <= r_iss_vld;
      r_tag_id[0]  <= r_iss_id;
      for (int k = 1; k < LATENCY; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
      // Work launched before reset may still drain out of the datapath.
      if (r_guard != '0) r_guard <= r_guard - c_gw'(1);
      if (((r_guard == '0) && (dp_out_valid != r_tag_vld[LATENCY-1])) || w_ovf)
        r_err <= 1'b1;
    end
  end

  assign w_push = dp_out_valid & r_tag_vld[LATENCY-1];

  always_comb begin
    w_din      = '0;
    w_din.id   = MV_ID_W'(r_tag_id[LATENCY-1]);
    w_din.data = dp_o;
  end

  mv_sched_fifo #(
    .DEPTH (DEPTH),
    .T     (rsp_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_din      (w_din),
    .i_pop      (rsp_ready),
    .o_dout     (w_dout),
    .o_count    (w_cnt),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_overflow (w_ovf)
  );

  assign req_ready   = w_gnt;
  assign dp_in_valid = r_iss_vld;
  assign dp_m_valid  = r_iss_vld;
  assign dp_v        = r_dp_v;
  assign dp_m        = r_dp_m;
  assign rsp_valid   = ~w_empty;
  assign rsp_id      = IDW'(w_dout.id);
  assign rsp_data    = w_dout.data;
  assign busy        = (w_inflight != 0) || ~w_empty;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mv_sched.sv
`default_nettype none
// +-------------------------------------------------------------+
// | tb_mv_sched : directed bench with a behavioural fp32 MxV    |
// | Revision    : 1.0                                           |
// +-------------------------------------------------------------+
module tb_mv_sched;
  import mv_sched_pkg::*;

  localparam int c_nreq  = 2;
  localparam int c_lat   = 4;
  localparam int c_depth = 8;
  localparam int c_idw   = 1;

  localparam logic [127:0] c_v0   = 128'h40800000_40400000_40000000_3F800000;
  localparam logic [127:0] c_v1   = 128'h41000000_40E00000_40C00000_40A00000;
  localparam logic [127:0] c_v0x2 = 128'h41000000_40C00000_40800000_40000000;
  localparam logic [127:0] c_v1x2 = 128'h41800000_41600000_41400000_41200000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [c_nreq-1:0]     mat_ld;
  logic [511:0]          mat_i;
  logic [c_nreq-1:0]     req_valid;
  logic [c_nreq-1:0]     req_ready;
  logic [c_nreq*128-1:0] req_vec;
  logic                  dp_m_valid;
  logic [511:0]          dp_m;
  logic                  dp_in_valid;
  logic [127:0]          dp_v;
  logic                  dp_out_valid;
  logic [127:0]          dp_o;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [c_idw-1:0]      rsp_id;
  logic [127:0]          rsp_data;
  logic                  busy;
  logic                  err;

  always #5 clk = ~clk;

  mv_sched #(
    .NREQ    (c_nreq),
    .LATENCY (c_lat),
    .DEPTH   (c_depth)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mat_ld       (mat_ld),
    .mat_i        (mat_i),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_vec      (req_vec),
    .dp_m_valid   (dp_m_valid),
    .dp_m         (dp_m),
    .dp_in_valid  (dp_in_valid),
    .dp_v         (dp_v),
    .dp_out_valid (dp_out_valid),
    .dp_o         (dp_o),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .err          (err)
  );

  // fp32 <-> real, exact for the small integer values used here
  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic        s;
    int          e;
    real         a;
    logic [22:0] man;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    man = 23'($rtoi((a - 1.0) * 8388608.0));
    return {s, 8'(e + 127), man};
  endfunction

  function automatic logic [127:0] mv_model(input mat4_t m, input vec4_t v);
    vec4_t o;
    real   acc;
    for (int i = 0; i < 4; i++) begin
      acc = 0.0;
      for (int j = 0; j < 4; j++) acc += f2r(m[i*4+j]) * f2r(v[j]);
      o[i] = r2f(acc);
    end
    return o;
  endfunction

  function automatic logic [511:0] mk_diag(input logic [31:0] d);
    mat4_t m;
    m     = '0;
    m[0]  = d;
    m[5]  = d;
    m[10] = d;
    m[15] = d;
    return m;
  endfunction

  // Behavioural datapath: fixed latency, no stall, no reset.
  logic [c_lat-1:0] dpm_vld = '0;
  logic [127:0]     dpm_dat [c_lat];
  logic             force_dpo = 1'b0;

  always @(posedge clk) begin
    dpm_vld    <= {dpm_vld[c_lat-2:0], dp_in_valid};
    dpm_dat[0] <= mv_model(dp_m, dp_v);
    for (int k = 1; k < c_lat; k++) dpm_dat[k] <= dpm_dat[k-1];
  end

  assign dp_out_valid = dpm_vld[c_lat-1] | force_dpo;
  assign dp_o         = force_dpo ? 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF : dpm_dat[c_lat-1];

  logic [c_idw+127:0] rq [$];

  always @(negedge clk) begin
    #4;
    if (rsp_valid && rsp_ready) rq.push_back({rsp_id, rsp_data});
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [c_idw+127:0] get_rq(input int i);
    if (i < rq.size()) return rq[i];
    return '1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [c_nreq-1:0] sel, input logic [511:0] m);
    mat_ld = sel;
    mat_i  = m;
    tick();
    mat_ld = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || rsp_valid) && n < 100) begin tick(); n++; end
    tick();
    check(tag, busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int           n;
    int           ng;
    logic [511:0] m_i;
    logic [511:0] m_2i;

    m_i       = mk_diag(32'h3F800000);
    m_2i      = mk_diag(32'h40000000);
    rst       = 1'b1;
    mat_ld    = '0;
    mat_i     = '0;
    req_valid = '0;
    req_vec   = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();

    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_dp_in_valid", dp_in_valid, 1'b0);
    check("rst_dp_m", dp_m, 512'h0);
    check("rst_req_ready", req_ready, 2'b00);
    rst = 1'b0;
    repeat (8) tick();

    // identity on requester 0
    load(2'b01, m_i);
    req_vec[127:0] = c_v0;
    req_valid      = 2'b01;
    #1 check("t1_grant", req_ready, 2'b01);
    tick();
    req_valid = '0;
    #1;
    check("t1_dp_in_valid", dp_in_valid, 1'b1);
    check("t1_dp_m_valid", dp_m_valid, 1'b1);
    check("t1_dp_v", dp_v, c_v0);
    check("t1_dp_m", dp_m, m_i);
    check("t1_busy", busy, 1'b1);
    n = 1;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    check("t1_latency", n, 6);
    check("t1_id", rsp_id, 1'b0);
    check("t1_data", rsp_data, c_v0);
    wait_idle("t1_idle");

    // two requesters alternating
    do_reset();
    load(2'b01, m_i);
    load(2'b10, m_2i);
    rq.delete();
    req_vec   = {c_v1, c_v0};
    req_valid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      #1 check($sformatf("t2_gnt%0d", c), req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    req_valid = '0;
    n = 0;
    while (rq.size() < 8 && n < 60) begin tick(); n++; end
    check("t2_count", rq.size(), 8);
    for (int c = 0; c < 8; c++)
      check($sformatf("t2_rsp%0d", c), get_rq(c),
            (c % 2 == 0) ? {1'b0, c_v0} : {1'b1, c_v1x2});
    check("t2_err", err, 1'b0);
    wait_idle("t2_idle");

    // credit exhaustion with a stalled consumer
    rq.delete();
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    ng = 0;
    for (int c = 0; c < 20; c++) begin
      #1 ng += $countones(req_ready);
      tick();
    end
    check("t3_grants", ng, 8);
    #1;
    check("t3_stalled", req_ready, 2'b00);
    check("t3_busy", busy, 1'b1);
    check("t3_rsp_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    #1 check("t3_pop_cycle", req_ready, 2'b00);
    tick();
    for (int c = 0; c < 4; c++) begin
      #1 check($sformatf("t3_refill%0d", c), $countones(req_ready), 1);
      tick();
    end
    req_valid = '0;
    wait_idle("t3_idle");
    check("t3_count", rq.size(), 12);
    for (int c = 0; c < 8; c++)
      check($sformatf("t3_rsp%0d", c), get_rq(c),
            (c % 2 == 0) ? {1'b0, c_v0} : {1'b1, c_v1x2});
    check("t3_err", err, 1'b0);

    // requester without a matrix is never granted
    do_reset();
    rq.delete();
    req_vec   = {c_v1, c_v0};
    req_valid = 2'b10;
    for (int c = 0; c < 4; c++) begin
      #1 check($sformatf("t4_blocked%0d", c), req_ready, 2'b00);
      tick();
    end
    mat_ld = 2'b10;
    mat_i  = m_2i;
    #1 check("t4_ld_cycle", req_ready, 2'b00);
    tick();
    mat_ld = '0;
    #1 check("t4_first", req_ready, 2'b10);
    tick();
    req_valid = '0;
    wait_idle("t4_idle");
    check("t4_count", rq.size(), 1);
    check("t4_rsp", get_rq(0), {1'b1, c_v1x2});

    // reload racing a grant: old matrix for this grant, new for the next
    rq.delete();
    load(2'b01, m_i);
    req_valid = 2'b01;
    mat_ld    = 2'b01;
    mat_i     = m_2i;
    #1 check("t5_gnt_old", req_ready, 2'b01);
    tick();
    mat_ld = '0;
    #1 check("t5_gnt_new", req_ready, 2'b01);
    tick();
    req_valid = '0;
    wait_idle("t5_idle");
    check("t5_count", rq.size(), 2);
    check("t5_rsp0", get_rq(0), {1'b0, c_v0});
    check("t5_rsp1", get_rq(1), {1'b0, c_v0x2});

    // reset with results buffered and work in flight
    rq.delete();
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    tick();
    tick();
    req_valid = '0;
    repeat (6) tick();
    #1 check("t6_pre_valid", rsp_valid, 1'b1);
    req_valid = 2'b01;
    repeat (3) tick();
    req_valid = '0;
    #1 check("t6_pre_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rsp_valid", rsp_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_err", err, 1'b0);
    rsp_ready = 1'b1;
    repeat (12) tick();
    check("t6_no_rsp", rq.size(), 0);
    check("t6_err_late", err, 1'b0);
    force_dpo = 1'b1;
    tick();
    force_dpo = 1'b0;
    #1;
    check("t6_spurious_err", err, 1'b1);
    check("t6_spurious_fifo", rsp_valid, 1'b0);
    check("t6_spurious_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mv_sched.md
Name: mv_sched

Overview:
- Request scheduler and result buffer for the mv_mul_4x4_fp32 pipeline.
- Holds one 4x4 fp32 matrix per requester and round-robins vector requests from NREQ clients into the shared datapath.
- Tags every issued vector and collects results into an output FIFO with valid/ready.
- The datapath has no stall, so issue is credit-gated: a result always has a FIFO slot when it emerges.

Parameters:
NREQ, 2, number of requesters (2..8)
LATENCY, 4, datapath latency in cycles, dp_in_valid to dp_out_valid
DEPTH, 8, output FIFO entries (power of 2, >= 2)
IDW, $clog2(NREQ) min 1, requester id width

Ports:
clk  in  1  clock
rst  in  1  reset
mat_ld  in  NREQ  per-requester matrix load strobe
mat_i  in  512  matrix row-major; m00 = [31:0], m01 = [63:32] ... m33 = [511:480]
req_valid  in  NREQ  vector request valid
req_ready  out  NREQ  request accepted this cycle
req_vec  in  NREQ*128  per requester {w,z,y,x}; x = [31:0]
dp_m_valid  out  1  to datapath m_valid
dp_m  out  512  to datapath m00_i..m33_i, same packing as mat_i
dp_in_valid  out  1  to datapath in_valid
dp_v  out  128  to datapath vx..vw
dp_out_valid  in  1  from datapath out_valid
dp_o  in  128  from datapath {ow,oz,oy,ox}
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts
rsp_id  out  IDW  requester id of the result
rsp_data  out  128  result {ow,oz,oy,ox}
busy  out  1  any request in flight or FIFO non-empty
err  out  1  sticky protocol error

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- Reset: all outputs 0. mat_vld[] cleared, rr pointer = 0, tag pipe cleared, FIFO emptied, err cleared. Reset mid-operation drops all in-flight work. Datapath outputs arriving after reset are ignored, because the tag pipe is cleared and suppresses the err check for LATENCY+1 cycles.
- Matrix load: mat_ld[r] writes mat_i into bank r and sets mat_vld[r] at the clock edge. If several bits are set in one cycle, all selected banks load.
- Issue eligibility: requester r is eligible when req_valid[r], mat_vld[r] and credit_ok are all true.
  - credit_ok = (fifo_cnt + inflight) < DEPTH.
  - inflight = issue register + tag pipe occupancy.
  - A FIFO pop frees credit in the next cycle, not the same cycle.
- Arbitration: round-robin starting at the rr pointer. At most one req_ready bit is high per cycle. On a grant to requester g, the pointer becomes g+1 mod NREQ. The pointer is unchanged when there is no grant.
- req_ready is combinational from req_valid, mat_vld and credit. Requesters must not make valid depend on ready.
- Issue register: on a grant in cycle T, in cycle T+1 the block drives:
  - dp_in_valid = 1, dp_m_valid = 1
  - dp_v = granted vector
  - dp_m = bank g as it was at cycle T. A mat_ld to the same bank in cycle T takes effect only from the next grant.
  - dp_m and dp_v hold their last value while idle; dp_m_valid = dp_in_valid.
- Tag pipe: a LATENCY-deep shift of {valid, id} that aligns with dp_out_valid.
  - When dp_out_valid is 1 and the pipe tail is valid, {tail id, dp_o} is pushed into the FIFO.
  - When dp_out_valid and the tail valid bit disagree, err is set (sticky). Nothing is pushed on a spurious output.
- FIFO: DEPTH entries of {id, 128b}. Registered outputs.
  - rsp_valid = non-empty; pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop is allowed at any occupancy, including full.
  - A push when full cannot occur under the credit rule; if it does, set err and drop the entry.
  - Pointers wrap mod DEPTH; count range is 0..DEPTH.
- Latency: grant at T gives dp_in_valid at T+1, dp_out_valid at T+1+LATENCY, and rsp_valid at T+2+LATENCY when the FIFO was empty.
- Throughput: one vector per cycle while the consumer keeps rsp_ready = 1.
- Ordering: results leave in issue order across all requesters.

Decomposition:
- Package mv_sched_pkg:
  - vec4_t, packed 4x32
  - mat4_t, packed 16x32
  - rsp_t, {id, vec4_t}
  - MV_LATENCY = 4, the default for LATENCY
- Sub-module mv_sched_fifo: parameterised by DEPTH and the entry type. Provides push, pop, count, full, empty.
- Arbiter, tag pipe and credit logic stay in mv_sched.

Test Plan:
- Identity matrix loaded into requester 0; req0 vector {40800000,40400000,40000000,3F800000} -> rsp_valid 6 cycles after the grant, rsp_id = 0, rsp_data equal to the input vector.
- Both requesters valid continuously for 8 cycles, both matrices loaded, rsp_ready = 1 -> grants alternate 0,1,0,1,...; rsp_id sequence is 0,1,0,1... in order; rsp_data matches a scaled-matrix golden per requester (req1 matrix = 2.0*I, so outputs are doubled).
- rsp_ready = 0 with DEPTH = 8 and requests always valid -> exactly 8 grants, then req_ready = 0 indefinitely. Raise rsp_ready -> one new grant per pop, each one cycle after that pop; no err.
- req1 valid with mat_vld[1] = 0 -> req1 never granted. Then mat_ld[1] in cycle T with req1 valid -> first grant at T+1, using the new matrix.
- mat_ld[0] with 2.0*I in the same cycle req0 is granted (old matrix I) -> that result uses I; the next request's result is doubled.
- Assert rst while 3 requests are in flight and the FIFO holds 2 entries -> the next cycle has rsp_valid = 0, busy = 0, err = 0, and no later response appears. A forced spurious dp_out_valid after the guard window sets err = 1 and leaves the FIFO unchanged.
